// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Addresses are widened to 64 bits so the helpers work for any PC width up to that.
package imem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Byte address to word index relative to the memory base.
  function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port for the loader and
// one registered read port for fetch.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; sequential
  // state is always written with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_loadable.sv
// Writable instruction memory: loader handshake fills the RAM after reset,
// then fetch reads with one-cycle latency, stall, flush and reload support.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  input  logic                       reload,
  input  logic                       if_en,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          if_addr,
  output logic [DATA_W-1:0]          inst,
  output logic                       inst_valid,
  output logic                       addr_err,
  output logic [$clog2(DEPTH+1)-1:0] load_count,
  output logic                       running
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic [63:0]       addr_w, base_w, idx_w;
  logic              fetch_err, fetch_hit;
  logic              ld_fire, rd_en;
  logic [DATA_W-1:0] ram_rd;

  // Fetch decode: an address below the base wraps to a huge index, so the
  // DEPTH compare covers it as well.
  assign addr_w    = 64'(if_addr);
  assign base_w    = 64'(BASE_ADDR);
  assign idx_w     = word_index(addr_w, base_w);
  assign fetch_err = !word_aligned(if_addr[1:0]) || (addr_w < base_w) || (idx_w >= 64'(DEPTH));
  assign fetch_hit = !fetch_err && (idx_w < 64'(cnt_q));

  assign ld_ready = (state_q == S_LOAD) && (cnt_q < DEPTH_C);
  assign ld_fire  = ld_valid && ld_ready;
  assign rd_en    = (state_q == S_RUN) && !reload && !flush && if_en && fetch_hit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    err_d   = err_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        if (ld_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (ld_last || cnt_q == LAST_C) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (reload) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          valid_d = 1'b0;
        end else if (flush) begin
          hit_d   = 1'b0;
          err_d   = 1'b0;
          valid_d = 1'b1;
        end else if (if_en) begin
          hit_d   = fetch_hit;
          err_d   = fetch_err;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  imem_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ld_fire),
    .wr_idx (cnt_q[IDX_W-1:0]),
    .wr_data(ld_data),
    .rd_en  (rd_en),
    .rd_idx (idx_w[IDX_W-1:0]),
    .rd_data(ram_rd)
  );

  // RAM data is only shown when the last fetch hit loaded memory; the read
  // register holds on stall, so no separate output data register is needed.
  assign inst       = hit_q ? ram_rd : NOP_WORD;
  assign inst_valid = valid_q;
  assign addr_err   = err_q;
  assign load_count = cnt_q;
  assign running    = (state_q == S_RUN);

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable against a word-array reference model.
module tb_imem_loadable;

  localparam int          DEPTH  = 16;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          CNT_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_valid, ld_last, reload, if_en, flush;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] if_addr;
  logic              ld_ready, inst_valid, addr_err, running;
  logic [DATA_W-1:0] inst;
  logic [CNT_W-1:0]  load_count;

  imem_loadable #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .reload    (reload),
    .if_en     (if_en),
    .flush     (flush),
    .if_addr   (if_addr),
    .inst      (inst),
    .inst_valid(inst_valid),
    .addr_err  (addr_err),
    .load_count(load_count),
    .running   (running)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: loaded words, count, run flag, and last fetch result {inst, err, valid}.
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  bit          m_run;
  logic [33:0] m_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] exp_fetch(input logic [31:0] a);
    int unsigned idx;
    if (a % 4 != 0) return {NOP, 2'b11};
    idx = a / 4;
    if (idx >= DEPTH) return {NOP, 2'b11};
    if (idx >= m_count) return {NOP, 2'b01};
    return {m_mem[idx], 2'b01};
  endfunction

  task automatic load_words(input logic [31:0] words[$], input bit use_last, input bit bp);
    int n   = 0;
    int cyc = 0;
    bit v, exp_rdy;
    while (n < words.size() && cyc < 400) begin
      v        = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      ld_valid = v;
      ld_data  = words[n];
      ld_last  = use_last && (n == words.size() - 1);
      exp_rdy  = !m_run && (m_count < DEPTH);
      checks++;
      if (ld_ready !== exp_rdy) begin
        failures++;
        $display("FAIL ld_ready_during_load: got %b exp %b", ld_ready, exp_rdy);
      end
      tick();
      cyc++;
      if (v && exp_rdy) begin
        m_mem[m_count] = words[n];
        m_count++;
        if (ld_last || m_count == DEPTH) m_run = 1'b1;
        n++;
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checks++;
    if (n < words.size()) begin
      failures++;
      $display("FAIL load_timeout: accepted %0d exp %0d", n, words.size());
    end
    checks++;
    if ({running, load_count} !== {m_run, CNT_W'(m_count)}) begin
      failures++;
      $display("FAIL load_status: got run=%b cnt=%0d exp run=%b cnt=%0d",
               running, load_count, m_run, m_count);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input bit fl, input string name);
    if_en   = 1'b1;
    if_addr = a;
    flush   = fl;
    tick();
    if_en = 1'b0;
    flush = 1'b0;
    m_out = fl ? {NOP, 2'b01} : exp_fetch(a);
    checks++;
    if ({inst, addr_err, inst_valid} !== m_out) begin
      failures++;
      $display("FAIL %s addr=%h: got inst=%h err=%b vld=%b exp inst=%h err=%b vld=%b",
               name, a, inst, addr_err, inst_valid, m_out[33:2], m_out[1], m_out[0]);
    end
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      if_en   = 1'b0;
      flush   = 1'b0;
      if_addr = $urandom;
      tick();
      checks++;
      if ({inst, addr_err, inst_valid} !== m_out) begin
        failures++;
        $display("FAIL stall_hold: got %h/%b/%b exp %h/%b/%b",
                 inst, addr_err, inst_valid, m_out[33:2], m_out[1], m_out[0]);
      end
    end
  endtask

  task automatic do_reload(input bit fl, input bit en);
    reload  = 1'b1;
    flush   = fl;
    if_en   = en;
    if_addr = '0;
    tick();
    reload  = 1'b0;
    flush   = 1'b0;
    if_en   = 1'b0;
    m_run   = 1'b0;
    m_count = 0;
    m_out   = {NOP, 2'b00};
    checks++;
    if ({running, ld_ready, load_count, inst, addr_err, inst_valid} !==
        {1'b0, 1'b1, CNT_W'(0), NOP, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reload: got run=%b rdy=%b cnt=%0d inst=%h err=%b vld=%b",
               running, ld_ready, load_count, inst, addr_err, inst_valid);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({ld_ready, inst, inst_valid, addr_err, load_count, running} !==
        {1'b0, NOP, 1'b0, 1'b0, CNT_W'(0), 1'b0}) begin
      failures++;
      $display("FAIL %s: got rdy=%b inst=%h vld=%b err=%b cnt=%0d run=%b exp all reset values",
               name, ld_ready, inst, inst_valid, addr_err, load_count, running);
    end
  endtask

  // Release reset and confirm ld_ready only rises after the IDLE cycle.
  task automatic release_reset();
    reset = 1'b0;
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL ld_ready_idle: got %b exp 0", ld_ready);
    end
    tick();
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL ld_ready_rise: got %b exp 1", ld_ready);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    reload   = 1'b0;
    if_en    = 1'b0;
    flush    = 1'b0;
    if_addr  = '0;
    m_count  = 0;
    m_run    = 1'b0;
    m_out    = {NOP, 2'b00};
    #3;
    check_reset_vals("reset_values");
    tick();
    tick();
    release_reset();
  endtask

  task automatic test_basic_load();
    logic [31:0] q[$];
    q = '{32'h3C01_6165, 32'h3421_6165, 32'h0001_4020, 32'hAC08_0000};
    load_words(q, 1'b1, 1'b0);
    fetch(32'h0, 1'b0, "fetch_w0");
    fetch(32'h4, 1'b0, "fetch_w1");
    fetch(32'h8, 1'b0, "fetch_w2");
    fetch(32'hC, 1'b0, "fetch_w3");
  endtask

  task automatic test_unloaded();
    fetch(32'h10, 1'b0, "fetch_unloaded");
    fetch(32'h2, 1'b0, "fetch_misaligned");
    fetch(32'(4 * DEPTH), 1'b0, "fetch_out_of_range");
  endtask

  task automatic test_stall_flush();
    fetch(32'h4, 1'b0, "fetch_before_stall");
    stall(3);
    fetch(32'h2, 1'b0, "fetch_err_before_flush");
    fetch(32'h0, 1'b1, "flush_nop");
    stall(2);
    do_reload(1'b1, 1'b1);
  endtask

  task automatic test_full_load();
    logic [31:0] q[$];
    for (int i = 0; i < DEPTH; i++) q.push_back($urandom);
    load_words(q, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
      checks++;
      if (ld_ready !== 1'b0) begin
        failures++;
        $display("FAIL ld_ready_when_full: got %b exp 0", ld_ready);
      end
      tick();
    end
    ld_valid = 1'b0;
    checks++;
    if ({running, load_count} !== {1'b1, CNT_W'(DEPTH)}) begin
      failures++;
      $display("FAIL full_ignore: got run=%b cnt=%0d exp run=1 cnt=%0d", running, load_count, DEPTH);
    end
    fetch(32'(4 * (DEPTH - 1)), 1'b0, "fetch_last_word");
    fetch(32'(4 * DEPTH), 1'b0, "fetch_depth_boundary");
    for (int i = 0; i < 6; i++) fetch(32'($urandom_range(0, DEPTH - 1) * 4), 1'b0, "fetch_full_rand");
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    do_reload(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) q.push_back($urandom);
    load_words(q, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) fetch(32'(4 * i), 1'b0, "fetch_bp_word");
    fetch(32'(4 * 10), 1'b0, "fetch_bp_unloaded");
  endtask

  task automatic test_random_fetch();
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 4 * DEPTH + 8);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) stall(1);
      else fetch(a, $urandom_range(0, 5) == 0, "fetch_random");
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] q[$];
    do_reload(1'b0, 1'b0);
    q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    load_words(q, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    m_count = 0;
    m_run   = 1'b0;
    m_out   = {NOP, 2'b00};
    check_reset_vals("reset_midload");
    tick();
    release_reset();
    q = '{32'hAAAA_0001, 32'hBBBB_0002};
    load_words(q, 1'b1, 1'b0);
    fetch(32'h8, 1'b0, "fetch_stale_after_reset");
    fetch(32'h0, 1'b0, "fetch_new_w0");
    fetch(32'h4, 1'b0, "fetch_new_w1");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_unloaded();
    test_stall_flush();
    test_full_load();
    test_backpressure();
    test_random_fetch();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
